// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared types and helpers for the trap controller.
//   priv_t           : RISC-V privilege encodings (U/S/M)
//   trap_state_t     : trap handshake FSM states
//   EXC_ILLEGAL_INSN : cause code raised for mret outside M-mode
//   make_cause()     : builds an mcause image; callers cast it to their XLEN
// -----------------------------------------------------------------------------
package trap_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTER,
        ST_RETURN
    } trap_state_t;

    localparam logic [4:0] EXC_ILLEGAL_INSN = 5'd2;

    // Widest cause image supported and width of the code field handed in.
    localparam int CAUSE_MAX_W = 64;
    localparam int CODE_W      = 8;

    // Interrupt flag goes to bit 'msb' (XLEN-1 of the caller), code sits in the
    // low bits; everything in between is zero.
    function automatic logic [CAUSE_MAX_W-1:0] make_cause(
        input logic              is_int,
        input logic [CODE_W-1:0] code,
        input logic [5:0]        msb
    );
        logic [CAUSE_MAX_W-1:0] c;
        c              = '0;
        c[CODE_W-1:0]  = code;
        c[msb]         = is_int;
        return c;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder: the lowest set request bit wins.
//   req_i   [NUM_IRQ-1:0] : request vector
//   valid_o               : at least one request set
//   idx_o   [IDX_W-1:0]   : index of the winning (lowest) request
// -----------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int NUM_IRQ = 16,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise an
        // all-zero request would leave them unassigned and infer a latch.
        valid_o = 1'b0;
        idx_o   = '0;
        // Scan from the top down so the last hit, the lowest index, sticks.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Trap controller between the control unit and the CSR unit. Owns interrupt
// pending state, arbitrates exception vs interrupts, runs the trap entry /
// return handshake and tracks current (cpm) and previous (mpp) privilege.
//   clk, rst        : clock, asynchronous active-high reset
//   irq_in          : raw interrupt lines (synchronous to clk)
//   irq_en          : per-source enable (mie image)
//   global_ie       : mstatus.MIE
//   insn_boundary   : instruction retiring; only point where a trap/return starts
//   exc_req/exc_code: synchronous exception and its cause code
//   mret            : mret decoded
//   trap_ack        : CSR unit has saved epc/status
//   ip              : pending vector (mip image)
//   trap_take       : trap entry request, held until trap_ack
//   trap_return     : one-cycle restore pulse
//   trap_cause      : mcause value, is_interrupt is its MSB
//   cpm             : current privilege mode
//   busy            : handshake in progress; fetch must stall
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int                 XLEN      = 32,
    parameter int                 NUM_IRQ   = 16,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
    parameter int                 IDX_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               global_ie,
    input  logic               insn_boundary,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic               mret,
    input  logic               trap_ack,
    output logic [NUM_IRQ-1:0] ip,
    output logic               trap_take,
    output logic               trap_return,
    output logic [XLEN-1:0]    trap_cause,
    output logic               is_interrupt,
    output logic [1:0]         cpm,
    output logic               busy
);

    localparam logic [5:0] CAUSE_MSB = 6'(XLEN - 1);

    trap_state_t        state_q;
    priv_t              cpm_q;
    priv_t              mpp_q;
    logic               trap_take_q;
    logic               trap_return_q;
    logic               busy_q;
    logic [XLEN-1:0]    cause_q;
    logic [IDX_W-1:0]   win_idx_q;

    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] edge_d;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] edge_clr;
    logic [NUM_IRQ-1:0] eligible;
    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;

    // ------------------------------------------------------------------------
    // Pending state: level sources are transparent, edge sources are latched.
    // ------------------------------------------------------------------------
    assign ip       = (irq_in & ~EDGE_MASK) | (edge_q & EDGE_MASK);
    assign edge_set = irq_in & ~prev_q & EDGE_MASK;

    // The latch of the source that won the trap is consumed on the ack.
    always_comb begin
        edge_clr = '0;
        if (state_q == ST_ENTER && trap_ack && cause_q[XLEN-1]) begin
            edge_clr[win_idx_q] = 1'b1;
        end
    end

    // A new rising edge in the ack cycle re-arms the latch (set wins).
    assign edge_d = (edge_q & ~edge_clr) | edge_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            prev_q <= irq_in;
            edge_q <= edge_d;
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration. Below M-mode interrupts are taken regardless of global_ie.
    // ------------------------------------------------------------------------
    assign eligible = ip & irq_en & {NUM_IRQ{global_ie | (cpm_q != PRIV_M)}};

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req_i   (eligible),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

    // ------------------------------------------------------------------------
    // Trap handshake FSM with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the reset branch covers every register here, so an abandoned
        // trap leaves nothing behind once rst is raised.
        if (rst) begin
            state_q       <= ST_IDLE;
            cpm_q         <= PRIV_M;
            mpp_q         <= PRIV_M;
            trap_take_q   <= 1'b0;
            trap_return_q <= 1'b0;
            busy_q        <= 1'b0;
            cause_q       <= '0;
            win_idx_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (insn_boundary) begin
                        if (exc_req) begin
                            // Exception beats interrupts and a same-cycle mret.
                            cause_q     <= XLEN'(make_cause(1'b0, CODE_W'(exc_code), CAUSE_MSB));
                            state_q     <= ST_ENTER;
                            trap_take_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else if (irq_valid) begin
                            cause_q     <= XLEN'(make_cause(1'b1, CODE_W'(irq_idx), CAUSE_MSB));
                            win_idx_q   <= irq_idx;
                            state_q     <= ST_ENTER;
                            trap_take_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else if (mret) begin
                            if (cpm_q == PRIV_M) begin
                                state_q       <= ST_RETURN;
                                trap_return_q <= 1'b1;
                                busy_q        <= 1'b1;
                            end else begin
                                // mret below M-mode is an illegal instruction.
                                cause_q     <= XLEN'(make_cause(1'b0, CODE_W'(EXC_ILLEGAL_INSN), CAUSE_MSB));
                                state_q     <= ST_ENTER;
                                trap_take_q <= 1'b1;
                                busy_q      <= 1'b1;
                            end
                        end
                    end
                end

                ST_ENTER: begin
                    // Cause is frozen here; only the ack moves the FSM.
                    if (trap_ack) begin
                        mpp_q       <= cpm_q;
                        cpm_q       <= PRIV_M;
                        trap_take_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_RETURN: begin
                    cpm_q         <= mpp_q;
                    mpp_q         <= PRIV_U;
                    trap_return_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= ST_IDLE;
                end

                default: begin
                    state_q       <= ST_IDLE;
                    trap_take_q   <= 1'b0;
                    trap_return_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign trap_take    = trap_take_q;
    assign trap_return  = trap_return_q;
    assign trap_cause   = cause_q;
    assign is_interrupt = cause_q[XLEN-1];
    assign cpm          = cpm_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Scoreboard bench for trap_ctrl. The driver predicts each boundary's outcome
// from the architectural rules (privilege, pending, priority) and queues it;
// an independent monitor pops an entry whenever the DUT raises trap_take or
// trap_return and compares the presented cause.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam int           XLEN  = 32;
    localparam int           N     = 16;
    localparam logic [N-1:0] EMASK = 16'h0A08;   // sources 3, 9, 11 are edge

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   irq_in;
    logic [N-1:0]   irq_en;
    logic           global_ie;
    logic           insn_boundary;
    logic           exc_req;
    logic [4:0]     exc_code;
    logic           mret;
    logic           trap_ack;
    logic [N-1:0]   ip;
    logic           trap_take;
    logic           trap_return;
    logic [XLEN-1:0] trap_cause;
    logic           is_interrupt;
    logic [1:0]     cpm;
    logic           busy;

    trap_ctrl #(
        .XLEN      (XLEN),
        .NUM_IRQ   (N),
        .EDGE_MASK (EMASK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_in        (irq_in),
        .irq_en        (irq_en),
        .global_ie     (global_ie),
        .insn_boundary (insn_boundary),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .mret          (mret),
        .trap_ack      (trap_ack),
        .ip            (ip),
        .trap_take     (trap_take),
        .trap_return   (trap_return),
        .trap_cause    (trap_cause),
        .is_interrupt  (is_interrupt),
        .cpm           (cpm),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ret;
        logic [31:0] cause;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: architectural view only.
    logic [1:0]   m_cpm, m_mpp;
    logic [N-1:0] m_edge, m_prev;
    logic [N-1:0] emask_v = EMASK;
    int           exp_kind;        // 0 nothing, 1 trap entry, 2 return
    int           exp_win;         // winning interrupt source, -1 if none

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_ip();
        return (irq_in & ~emask_v) | m_edge;
    endfunction

    task automatic model_reset();
        m_cpm  = 2'b11;
        m_mpp  = 2'b11;
        m_edge = '0;
        m_prev = '0;
    endtask

    // Apply source state, let edges latch for one cycle, then check ip.
    task automatic drive_pre(input logic [N-1:0] irq, input logic [N-1:0] en, input bit gie);
        @(negedge clk);
        irq_in        = irq;
        irq_en        = en;
        global_ie     = gie;
        insn_boundary = 1'b0;
        m_edge        = m_edge | (irq & ~m_prev & emask_v);
        m_prev        = irq;
        @(negedge clk);
        check("ip_pending", ip, m_ip());
    endtask

    // One retiring instruction: predict outcome, queue it, pulse boundary.
    task automatic issue(input bit exc, input logic [4:0] code, input bit mr);
        logic [N-1:0] gate, elig, iso;
        gate    = (global_ie || m_cpm != 2'b11) ? {N{1'b1}} : '0;
        elig    = m_ip() & irq_en & gate;
        exp_win = -1;
        if (exc) begin
            exp_kind = 1;
            sb_q.push_back('{is_ret: 1'b0, cause: {27'b0, code}});
        end else if (elig != 0) begin
            iso      = elig & (~elig + 1'b1);
            exp_win  = $clog2(iso);
            exp_kind = 1;
            sb_q.push_back('{is_ret: 1'b0, cause: 32'h8000_0000 | exp_win});
        end else if (mr && m_cpm == 2'b11) begin
            exp_kind = 2;
            sb_q.push_back('{is_ret: 1'b1, cause: 32'h0});
        end else if (mr) begin
            exp_kind = 1;
            sb_q.push_back('{is_ret: 1'b0, cause: 32'h2});
        end else begin
            exp_kind = 0;
        end
        insn_boundary = 1'b1;
        exc_req       = exc;
        exc_code      = code;
        mret          = mr;
        @(negedge clk);
        insn_boundary = 1'b0;
        exc_req       = 1'b0;
        mret          = 1'b0;
        if (exp_kind == 1) check("take_latency", trap_take, 1);
        if (exp_kind == 2) check("return_latency", trap_return, 1);
    endtask

    // Complete the handshake and check the architectural result.
    task automatic finish_txn(input bit drop);
        bit got;
        if (exp_kind == 1) begin
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                @(negedge clk);
                got = trap_take;
            end
            check("take_held", got, 1);
            if (drop) begin
                irq_in = '0;   // level sources vanish mid-entry
                m_prev = '0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            trap_ack = 1'b1;
            @(negedge clk);
            trap_ack = 1'b0;
            m_mpp = m_cpm;
            m_cpm = 2'b11;
            if (exp_win >= 0 && emask_v[exp_win]) m_edge[exp_win] = 1'b0;
            check("cpm_after_trap", cpm, m_cpm);
            check("take_dropped", trap_take, 0);
            check("ip_after_trap", ip, m_ip());
        end else if (exp_kind == 2) begin
            @(negedge clk);
            m_cpm = m_mpp;
            m_mpp = 2'b00;
            check("cpm_after_ret", cpm, m_cpm);
            check("ret_one_cycle", trap_return, 0);
            check("busy_after_ret", busy, 0);
        end else begin
            check("idle_busy", busy, 0);
            check("idle_take", trap_take, 0);
        end
    endtask

    // Monitor: pops the scoreboard on each DUT response.
    logic take_d = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            take_d = 1'b0;
        end else begin
            if (trap_take && !take_d) begin
                check("sb_has_take", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    cur = sb_q.pop_front();
                    check("kind_take", cur.is_ret, 0);
                    check("cause", trap_cause, cur.cause);
                    check("is_int", is_interrupt, cur.cause[31]);
                end
            end else if (trap_take) begin
                check("cause_stable", trap_cause, cur.cause);
            end
            if (trap_return) begin
                check("sb_has_ret", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    cur = sb_q.pop_front();
                    check("kind_ret", cur.is_ret, 1);
                end
            end
            take_d = trap_take;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq_in = '0; irq_en = '0; global_ie = 1'b0;
        insn_boundary = 1'b0; exc_req = 1'b0; exc_code = '0;
        mret = 1'b0; trap_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cpm", cpm, 2'b11);
        check("rst_ip", ip, 0);
        check("rst_take", trap_take, 0);
        check("rst_cause", trap_cause, 0);
        check("rst_busy", busy, 0);

        // Level interrupt 5, dropped while entry is pending.
        drive_pre(16'h0020, 16'h0020, 1'b1); issue(1'b0, 5'd0, 1'b0); finish_txn(1'b1);

        // Exception beats interrupts 2 and 9; then interrupt 2 wins.
        drive_pre(16'h0204, 16'h0204, 1'b1); issue(1'b1, 5'd13, 1'b0); finish_txn(1'b0);
        drive_pre(16'h0204, 16'h0204, 1'b1); issue(1'b0, 5'd0, 1'b0); finish_txn(1'b0);

        // Edge source 3 latched while masked, taken once enabled.
        drive_pre(16'h0008, 16'h0008, 1'b0); issue(1'b0, 5'd0, 1'b0); finish_txn(1'b0);
        drive_pre(16'h0000, 16'h0008, 1'b1); issue(1'b0, 5'd0, 1'b0); finish_txn(1'b0);

        // mret chain: M->M (mpp becomes U), M->U, then illegal mret in U.
        repeat (3) begin
            drive_pre(16'h0000, 16'h0000, 1'b1); issue(1'b0, 5'd0, 1'b1); finish_txn(1'b0);
        end

        // Exception and mret together: mret is dropped.
        drive_pre(16'h0000, 16'h0000, 1'b1); issue(1'b1, 5'd7, 1'b1); finish_txn(1'b0);

        // Randomised traffic.
        for (int t = 0; t < 300; t++) begin
            drive_pre(N'($urandom & $urandom), N'($urandom), 1'($urandom));
            issue(($urandom_range(0, 3) == 0), 5'($urandom), ($urandom_range(0, 3) == 0));
            finish_txn(($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a trap entry.
        drive_pre(16'h0000, 16'h0000, 1'b1); issue(1'b1, 5'd4, 1'b0);
        @(negedge clk);
        check("take_before_rst", trap_take, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_take", trap_take, 0);
        check("arst_busy", busy, 0);
        check("arst_ret", trap_return, 0);
        check("arst_cause", trap_cause, 0);
        check("arst_is_int", is_interrupt, 0);
        check("arst_cpm", cpm, 2'b11);
        check("arst_ip", ip, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Recovery after reset.
        drive_pre(16'h0020, 16'h0020, 1'b1); issue(1'b0, 5'd0, 1'b0); finish_txn(1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Parametrised trap controller between the control unit and the CSR unit. It generalises the fixed 32-bit trap link to NUM_IRQ sources with per-source edge/level mode, fixed-priority arbitration, exception-over-interrupt precedence, a trap entry/return handshake FSM and current/previous privilege tracking (cpm/mpp). It owns pending state, computes cause and drives trap entry/return toward the CSR unit.

Parameters:
XLEN, 32, width of cause output
NUM_IRQ, 16, number of interrupt sources; legal range 1..XLEN-1
EDGE_MASK, {NUM_IRQ{1'b0}}, bit i = 1: source i is rising-edge latched; 0: level
IDX_W, $clog2(NUM_IRQ) (min 1), width of winning-source index

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
irq_in  input  NUM_IRQ  raw interrupt lines, already synchronous to clk
irq_en  input  NUM_IRQ  per-source enable (mie image)
global_ie  input  1  global interrupt enable (mstatus.MIE)
insn_boundary  input  1  instruction retiring this cycle; only safe point to take or return
exc_req  input  1  synchronous exception from control unit
exc_code  input  5  exception cause code
mret  input  1  control unit decoded mret
trap_ack  input  1  CSR unit has saved epc/status
ip  output  NUM_IRQ  pending vector (to mip)
trap_take  output  1  trap entry request, held until ack
trap_return  output  1  one-cycle restore pulse
trap_cause  output  XLEN  cause for mcause
is_interrupt  output  1  trap_cause MSB copy
cpm  output  2  current privilege mode
busy  output  1  FSM not IDLE; control unit stalls fetch

Behaviour:
- Reset (async): state=IDLE, ip=0, edge latches=0, trap_take=0, trap_return=0, trap_cause=0, is_interrupt=0, cpm=2'b11, mpp=2'b11, busy=0.
- Pending: level source i: ip[i]=irq_in[i] (combinational). Edge source i: set on irq_in 0->1 (registered previous sample); cleared the cycle trap_ack arrives for a trap won by i. Set and clear in the same cycle: set wins.
- Eligible = ip & irq_en, gated by global_ie OR (cpm != 2'b11).
- Priority: exception > interrupt; among interrupts, lowest index wins.
- States: IDLE, ENTER, RETURN.
- IDLE, insn_boundary=1:
  - exc_req=1: register cause={1'b0, zero-extend exc_code}, go ENTER.
  - else eligible!=0: register cause={1'b1, zeros, idx}, go ENTER.
  - else mret=1 and cpm==2'b11: go RETURN.
  - else mret=1 and cpm!=2'b11: treat as exception code 2 (illegal instruction), go ENTER.
- IDLE, insn_boundary=0: no action; requests are not remembered except edge latches.
- ENTER: trap_take=1, busy=1, cause stable. On trap_ack: mpp<=cpm, cpm<=2'b11, clear winning edge latch, go IDLE. trap_take drops the cycle after ack. Min latency request->trap_take is 1 cycle.
- RETURN: trap_return=1 for exactly one cycle, cpm<=mpp, mpp<=2'b00, go IDLE.
- exc_req and mret in the same cycle: exception wins; mret dropped.
- Inputs other than trap_ack are ignored in ENTER/RETURN.
- Level source deasserting during ENTER: cause is unchanged; trap still completes.
- Reset mid-ENTER: trap abandoned, edge latches cleared, cpm back to M.

Decomposition:
- Package trap_pkg: priv_t enum (U=2'b00, S=2'b01, M=2'b11), trap_state_t enum (IDLE, ENTER, RETURN), constant EXC_ILLEGAL_INSN=5'd2, function make_cause(is_int, code).
- Sub-module irq_prio_enc (parametrised NUM_IRQ): lowest-index priority encoder; outputs valid and idx.

Test Plan:
1. Reset, then idle: cpm=3, ip=0, trap_take=0, trap_cause=0.
2. Level irq_in[5]=1, irq_en[5]=1, global_ie=1, boundary pulse -> next cycle trap_take=1, cause=0x80000005. Ack -> cpm=3, trap_take low the next cycle.
3. Simultaneous irq 2 and 9 enabled, plus exc_req code 13 at boundary -> cause=0x0000000D. After ack with irq still pending -> cause=0x80000002.
4. Edge source 3 (EDGE_MASK bit 3=1), 1-cycle irq_in pulse while global_ie=0 -> ip[3] stays 1. Set global_ie=1 at boundary -> trap cause=0x80000003. After ack -> ip[3]=0.
5. From M with mpp=U, mret at boundary -> trap_return pulses exactly 1 cycle, cpm=0. Second mret in U -> trap_take with cause=0x00000002.
6. Assert rst during ENTER -> all outputs return to reset values asynchronously, with no ack required.
